// File: rtl/fifo_wr_arbiter_if.sv
// Interface bundling the requester-side and FIFO-write-side signals of fifo_wr_arbiter.
//   req       : per-requester write request, held until granted
//   data_in   : requester i data at [i*DWIDTH +: DWIDTH]
//   gnt       : one-hot grant back to the requesters
//   fifo_full : FIFO full flag
//   fifo_wr   : FIFO write strobe
//   fifo_din  : FIFO write data
// Modport master is the arbiter side; slave is the producers/FIFO side.
interface fifo_wr_arbiter_if #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned DWIDTH = 8
);
   logic [NREQ-1:0]        req;
   logic [NREQ*DWIDTH-1:0] data_in;
   logic [NREQ-1:0]        gnt;
   logic                   fifo_full;
   logic                   fifo_wr;
   logic [DWIDTH-1:0]      fifo_din;

   modport master (
      input  req,
      input  data_in,
      input  fifo_full,
      output gnt,
      output fifo_wr,
      output fifo_din
   );

   modport slave (
      output req,
      output data_in,
      output fifo_full,
      input  gnt,
      input  fifo_wr,
      input  fifo_din
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one synchronous-FIFO write port among NREQ producers.
// Each winner may write up to BURST_MAX consecutive words before the pointer rotates.
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   en        : arbitration enable; 0 = no new grants
//   bus       : fifo_wr_arbiter_if.master (req, data_in, gnt, fifo_full, fifo_wr, fifo_din)
//   busy      : 1 while in the burst state
//   clr_stats : synchronous clear of stall_cnt
//   stall_cnt : saturating count of cycles with en & |req & fifo_full
module fifo_wr_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned DWIDTH    = 8,
   parameter int unsigned BURST_MAX = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   fifo_wr_arbiter_if.master          bus,
   output logic                       busy,
   input  logic                       clr_stats,
   output logic [15:0]                stall_cnt
);

   localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CntW = $clog2(BURST_MAX + 1);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e            state_q, state_d;
   logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PtrW-1:0]   owner_q, owner_d;
   logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
   logic [15:0]       stall_cnt_q, stall_cnt_d;

   logic              found;
   logic [PtrW-1:0]   sel;
   logic [NREQ-1:0]   gnt;
   logic [DWIDTH-1:0] din;
   logic              stall_event;

   // Increment modulo NREQ; NREQ need not be a power of two.
   function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
      logic [PtrW-1:0] r;
      if (32'(p) + 32'd1 == NREQ) begin
         r = '0;
      end else begin
         r = p + 1'b1;
      end
      return r;
   endfunction

   // Round-robin search starting at rr_ptr_q.
   always_comb begin
      int unsigned idx;
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = (32'(rr_ptr_q) + k) % NREQ;
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            sel   = PtrW'(idx);
         end
      end
   end

   // Next-state and grant logic.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      gnt        = '0;

      unique case (state_q)
         StIdle: begin
            if (en && found && !bus.fifo_full) begin
               gnt[sel]   = 1'b1;
               owner_d    = sel;
               beat_cnt_d = CntW'(1);
               if (BURST_MAX == 1) begin
                  rr_ptr_d = wrap_inc(sel);
               end else begin
                  state_d = StBurst;
               end
            end
         end
         StBurst: begin
            if (en && bus.req[owner_q]) begin
               // Full pauses the burst with beat_cnt held.
               if (!bus.fifo_full) begin
                  gnt[owner_q] = 1'b1;
                  beat_cnt_d   = beat_cnt_q + 1'b1;
                  if (32'(beat_cnt_q) + 32'd1 == BURST_MAX) begin
                     state_d  = StIdle;
                     rr_ptr_d = wrap_inc(owner_q);
                  end
               end
            end else begin
               // Owner dropped or arbitration disabled: one bubble, then rotate.
               state_d  = StIdle;
               rr_ptr_d = wrap_inc(owner_q);
            end
         end
         default: state_d = StIdle;
      endcase

      if (rst) begin
         gnt = '0;
      end
   end

   // Data mux; gnt is one-hot or zero so OR-reduction is a clean select.
   always_comb begin
      din = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            din = din | bus.data_in[i*DWIDTH +: DWIDTH];
         end
      end
   end

   assign stall_event = en & (|bus.req) & bus.fifo_full;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (clr_stats) begin
         stall_cnt_d = '0;
      end else if (stall_event && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         beat_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         beat_cnt_q  <= beat_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.gnt      = gnt;
   assign bus.fifo_wr  = |gnt;
   assign bus.fifo_din = din;
   assign busy         = (state_q == StBurst);
   assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (NREQ=4, DWIDTH=8, BURST_MAX=4).
// Expected per-cycle outputs are pushed to a scoreboard queue as stimulus is driven and
// popped/compared while the cycle's combinational outputs are stable (negedge).
module tb_fifo_wr_arbiter;

   localparam int unsigned NREQ   = 4;
   localparam int unsigned DWIDTH = 8;

   typedef struct packed {
      logic [3:0] gnt;
      logic       wr;
      logic [7:0] din;
      logic       busy;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        busy;
   logic        clr_stats;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   fifo_wr_arbiter_if #(.NREQ(NREQ), .DWIDTH(DWIDTH)) bus ();

   fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .BURST_MAX(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .bus       (bus),
      .busy      (busy),
      .clr_stats (clr_stats),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b1;
      bus.req = '0;
      bus.fifo_full = 1'b0;
      en = 1'b1;
      clr_stats = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      exp_t o;
      rst = 1'b1;
      en = 1'b1;
      clr_stats = 1'b0;
      bus.fifo_full = 1'b0;
      bus.req = 4'b1111;
      bus.data_in = 32'h3C2B1A55;
      @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++) begin
         if (c == 2) rst = 1'b0;
         e = (c == 2) ? '{gnt: 4'b0001, wr: 1'b1, din: 8'h55, busy: 1'b0}
                      : '{gnt: 4'b0000, wr: 1'b0, din: 8'h00, busy: 1'b0};
         sb.push_back(e);
         @(negedge clk);
         o = sb.pop_front();
         checks++;
         if (bus.gnt !== o.gnt || bus.fifo_wr !== o.wr || bus.fifo_din !== o.din ||
             busy !== o.busy || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset c%0d: got gnt=%b wr=%b din=%h busy=%b stall=%0d, exp gnt=%b wr=%b din=%h busy=%b stall=0",
                     c, bus.gnt, bus.fifo_wr, bus.fifo_din, busy, stall_cnt,
                     o.gnt, o.wr, o.din, o.busy);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_lone();
      exp_t e;
      exp_t o;
      do_reset();
      bus.req = 4'b0100;
      for (int i = 0; i < 6; i++) begin
         bus.data_in = 32'h0;
         bus.data_in[2*DWIDTH +: DWIDTH] = 8'(8'hA0 + i);
         e = '{gnt: 4'b0100, wr: 1'b1, din: 8'(8'hA0 + i),
               busy: ((i >= 1 && i <= 3) || i == 5)};
         sb.push_back(e);
         @(negedge clk);
         o = sb.pop_front();
         checks++;
         if (bus.gnt !== o.gnt || bus.fifo_wr !== o.wr || bus.fifo_din !== o.din ||
             busy !== o.busy) begin
            errors++;
            $display("FAIL lone beat%0d: got gnt=%b wr=%b din=%h busy=%b, exp gnt=%b wr=%b din=%h busy=%b",
                     i + 1, bus.gnt, bus.fifo_wr, bus.fifo_din, busy,
                     o.gnt, o.wr, o.din, o.busy);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_all_req();
      exp_t e;
      exp_t o;
      int lane;
      do_reset();
      bus.req = 4'b1111;
      bus.data_in = 32'h33323130;
      for (int i = 0; i < 20; i++) begin
         lane = (i / 4) % 4;
         e = '{gnt: 4'(1 << lane), wr: 1'b1, din: 8'(8'h30 + lane), busy: (i % 4) != 0};
         sb.push_back(e);
         @(negedge clk);
         o = sb.pop_front();
         checks++;
         if (bus.gnt !== o.gnt || bus.fifo_wr !== o.wr || bus.fifo_din !== o.din ||
             busy !== o.busy) begin
            errors++;
            $display("FAIL all_req c%0d: got gnt=%b wr=%b din=%h busy=%b, exp gnt=%b wr=%b din=%h busy=%b",
                     i, bus.gnt, bus.fifo_wr, bus.fifo_din, busy,
                     o.gnt, o.wr, o.din, o.busy);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_full_mid_burst();
      exp_t e;
      exp_t o;
      do_reset();
      bus.data_in = 32'h44332211;
      // beats 1,2; three full cycles; beats 3,4; then rotation to lane 0
      for (int c = 0; c < 8; c++) begin
         bus.req = (c == 7) ? 4'b0011 : 4'b0010;
         bus.fifo_full = (c >= 2 && c <= 4);
         if (c >= 2 && c <= 4) begin
            e = '{gnt: 4'b0000, wr: 1'b0, din: 8'h00, busy: 1'b1};
         end else if (c == 7) begin
            e = '{gnt: 4'b0001, wr: 1'b1, din: 8'h11, busy: 1'b0};
         end else begin
            e = '{gnt: 4'b0010, wr: 1'b1, din: 8'h22, busy: (c != 0)};
         end
         sb.push_back(e);
         @(negedge clk);
         o = sb.pop_front();
         checks++;
         if (bus.gnt !== o.gnt || bus.fifo_wr !== o.wr || bus.fifo_din !== o.din ||
             busy !== o.busy) begin
            errors++;
            $display("FAIL full_mid c%0d: got gnt=%b wr=%b din=%h busy=%b, exp gnt=%b wr=%b din=%h busy=%b",
                     c, bus.gnt, bus.fifo_wr, bus.fifo_din, busy,
                     o.gnt, o.wr, o.din, o.busy);
         end
         if (c == 5) begin
            checks++;
            if (stall_cnt !== 16'd3) begin
               errors++;
               $display("FAIL full_mid stall_cnt: got %0d, exp 3", stall_cnt);
            end
         end
         @(posedge clk);
         #1;
      end
      bus.fifo_full = 1'b0;
   endtask

   task automatic test_drop();
      exp_t e;
      exp_t o;
      do_reset();
      bus.data_in = 32'hD3C2B1A0;
      for (int c = 0; c < 4; c++) begin
         bus.req = (c < 2) ? 4'b1001 : 4'b1000;
         unique case (c)
            0: e = '{gnt: 4'b0001, wr: 1'b1, din: 8'hA0, busy: 1'b0};
            1: e = '{gnt: 4'b0001, wr: 1'b1, din: 8'hA0, busy: 1'b1};
            2: e = '{gnt: 4'b0000, wr: 1'b0, din: 8'h00, busy: 1'b1};
            default: e = '{gnt: 4'b1000, wr: 1'b1, din: 8'hD3, busy: 1'b0};
         endcase
         sb.push_back(e);
         @(negedge clk);
         o = sb.pop_front();
         checks++;
         if (bus.gnt !== o.gnt || bus.fifo_wr !== o.wr || bus.fifo_din !== o.din ||
             busy !== o.busy) begin
            errors++;
            $display("FAIL drop c%0d: got gnt=%b wr=%b din=%h busy=%b, exp gnt=%b wr=%b din=%h busy=%b",
                     c, bus.gnt, bus.fifo_wr, bus.fifo_din, busy,
                     o.gnt, o.wr, o.din, o.busy);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_stats();
      logic [15:0] exp_cnt [6];
      do_reset();
      bus.req = 4'b0001;
      bus.fifo_full = 1'b1;
      repeat (70000) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (stall_cnt !== 16'hFFFF || bus.fifo_wr !== 1'b0 || bus.gnt !== 4'b0000) begin
         errors++;
         $display("FAIL stats_sat: got stall=%h wr=%b gnt=%b, exp stall=ffff wr=0 gnt=0000",
                  stall_cnt, bus.fifo_wr, bus.gnt);
      end
      // cycle 0 clear during increment; 1 count; 2..4 en=0; 5 count again
      exp_cnt = '{16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0002};
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         clr_stats = (c == 0);
         en = !(c >= 2 && c <= 4);
         @(posedge clk);
         #1;
         clr_stats = 1'b0;
         en = 1'b0;
         @(negedge clk);
         checks++;
         if (stall_cnt !== exp_cnt[c]) begin
            errors++;
            $display("FAIL stats c%0d: got stall=%h, exp %h", c, stall_cnt, exp_cnt[c]);
         end
         if (c < 5) begin
            // Keep the count stable across the idle cycle before the next step.
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++;
            if (stall_cnt !== exp_cnt[c]) begin
               errors++;
               $display("FAIL stats_hold c%0d: got stall=%h, exp %h", c, stall_cnt, exp_cnt[c]);
            end
         end
      end
      en = 1'b1;
      bus.fifo_full = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      en = 1'b0;
      clr_stats = 1'b0;
      bus.req = '0;
      bus.data_in = '0;
      bus.fifo_full = 1'b0;
      test_reset();
      test_lone();
      test_all_req();
      test_full_mid_burst();
      test_drop();
      test_stats();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the single write port of the team's synchronous FIFO (wr/din/full) among NREQ producers. Each winner gets a bounded burst of up to BURST_MAX consecutive writes. The block never writes while the FIFO reports full, and it counts stall cycles for debug. The read side of the FIFO (rd/dout/empty) is outside this block and connects straight to the consumer.

Parameters:
NREQ, 4, number of requesters (2..8)
DWIDTH, 8, data width; must match the FIFO din width
BURST_MAX, 4, maximum consecutive grants to one owner before rotating (>=1)

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  synchronous active-high reset
en  input  1  arbitration enable; 0 = no new grants
req  input  NREQ  per-requester write request, held until granted
data_in  input  NREQ*DWIDTH  requester i data at [i*DWIDTH +: DWIDTH]
gnt  output  NREQ  one-hot, combinational; the requester's word is written this cycle
fifo_full  input  1  FIFO full flag
fifo_wr  output  1  FIFO write strobe, combinational, equals |gnt
fifo_din  output  DWIDTH  granted requester's data; 0 when there is no grant
busy  output  1  1 while in the BURST state
clr_stats  input  1  synchronous clear of stall_cnt
stall_cnt  output  16  saturating count of cycles where en & |req & fifo_full

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, stall_cnt=0.
  - While rst is high, gnt, fifo_wr and fifo_din are forced to 0.
  - Reset mid-burst abandons the burst. No write occurs in the reset cycle.
- Grant latency: zero cycles. gnt, fifo_wr and fifo_din are combinational from the current state and inputs. A requester's word is consumed at the edge that ends a cycle with its gnt bit set.
- IDLE:
  - If en & |req & !fifo_full: sel = first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - gnt[sel]=1; owner<=sel; beat_cnt<=1.
  - If BURST_MAX==1: stay IDLE, rr_ptr<=(sel+1) mod NREQ. Otherwise go to BURST.
  - Otherwise: no grant, no state change.
- BURST (owner fixed):
  - If en & req[owner] & !fifo_full: gnt[owner]=1; beat_cnt<=beat_cnt+1. If beat_cnt+1==BURST_MAX: go to IDLE, rr_ptr<=(owner+1) mod NREQ.
  - If en & req[owner] & fifo_full: no grant; stay in BURST with beat_cnt held (the burst is paused, not lost).
  - If !en or !req[owner]: no grant this cycle (one bubble); go to IDLE, rr_ptr<=(owner+1) mod NREQ.
- Burst exhaustion does not create a bubble. The next IDLE cycle can re-grant any requester, including the same one if it is the only one requesting.
- fifo_full has absolute priority: fifo_wr=0 in any cycle where fifo_full=1. A requester whose req drops without a grant loses nothing.
- stall_cnt:
  - +1 per cycle with en & |req & fifo_full; saturates at 16'hFFFF.
  - clr_stats=1 loads 0 and wins over a same-cycle increment.
- Requests in non-owner lanes during BURST are ignored and see gnt=0.
- gnt is always one-hot or zero.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with req=4'b1111, fifo_full=0 -> gnt=0, fifo_wr=0, busy=0, stall_cnt=0. Release: the first grant goes to req0 in the first cycle after rst=0.
2. Lone requester: req=4'b0100 held 6 cycles, data lane2 = 0xA0..0xA5 -> gnt=4'b0100 for 6 consecutive cycles, fifo_din sequence A0..A5, fifo_wr continuous. busy=1 during beats 2-4, 0 on beat 5, 1 on beat 6.
3. All requesting: req=4'b1111 continuous, fifo_full=0 -> grant order 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0..., fifo_wr=1 every cycle.
4. Full mid-burst: req1 burst, fifo_full=1 for 3 cycles after beat 2 -> gnt=0 and fifo_wr=0 for those 3 cycles, stall_cnt=3. req1 then completes beats 3 and 4, then rotates.
5. Drop mid-burst: req0 deasserts after beat 2 while req3=1 -> one cycle with gnt=0, then gnt=4'b1000 (rr_ptr=1 search finds lane 3).
6. Stats: req=1, fifo_full=1 for 70000 cycles -> stall_cnt=16'hFFFF and holds. clr_stats pulsed during an increment cycle -> stall_cnt=0 next cycle. en=0 with full -> no increment.
